// File: rtl/bp_l15_pkg.sv
// Shared types for the L1.5 fill engine: D-cache packet layouts, opcodes,
// coherence state and the fill FSM states.
package bp_l15_pkg;

    localparam int unsigned bp_index_width_lp = 6;
    localparam int unsigned bp_way_width_lp   = 3;
    localparam int unsigned bp_tag_width_lp   = 28;
    localparam int unsigned bp_block_width_lp = 512;

    typedef enum logic [1:0] {e_data_mem_write = 2'b01} bp_data_mem_opcode_e;
    typedef enum logic [1:0] {e_tag_mem_set_tag = 2'b01} bp_tag_mem_opcode_e;
    typedef enum logic [1:0] {e_stat_mem_set_clear = 2'b01} bp_stat_mem_opcode_e;
    typedef enum logic [2:0] {e_coh_exclusive = 3'b010} bp_coh_state_e;

    typedef enum logic [1:0] {e_ready, e_data, e_tag, e_stat} bp_fill_state_e;

    typedef struct packed {
        logic [1:0]                   opcode;
        logic [bp_index_width_lp-1:0] index;
        logic [bp_way_width_lp-1:0]   way;
        logic [bp_block_width_lp-1:0] data;
    } bp_data_mem_pkt_s;

    typedef struct packed {
        logic [1:0]                   opcode;
        logic [bp_index_width_lp-1:0] index;
        logic [bp_way_width_lp-1:0]   way;
        logic [2:0]                   state;
        logic [bp_tag_width_lp-1:0]   tag;
    } bp_tag_mem_pkt_s;

    typedef struct packed {
        logic [1:0]                   opcode;
        logic [bp_index_width_lp-1:0] index;
        logic [bp_way_width_lp-1:0]   way;
    } bp_stat_mem_pkt_s;

endpackage

// File: rtl/bp_l15_fill_engine.sv
// Writes one assembled miss line into the D-cache as data, tag, then stat
// packets, and pulses fill_done_o once the stat packet is consumed.
module bp_l15_fill_engine
    import bp_l15_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int sets_p        = 64,
    parameter int ways_p        = 8,
    parameter int block_width_p = 512
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       fill_v_i,
    input  logic [paddr_width_p-1:0]   fill_addr_i,
    input  logic [$clog2(ways_p)-1:0]  fill_way_i,
    input  logic [block_width_p-1:0]   fill_data_i,
    output logic                       fill_yumi_o,
    output bp_data_mem_pkt_s           data_mem_pkt_o,
    output logic                       data_mem_pkt_v_o,
    input  logic                       data_mem_pkt_yumi_i,
    output bp_tag_mem_pkt_s            tag_mem_pkt_o,
    output logic                       tag_mem_pkt_v_o,
    input  logic                       tag_mem_pkt_yumi_i,
    output bp_stat_mem_pkt_s           stat_mem_pkt_o,
    output logic                       stat_mem_pkt_v_o,
    input  logic                       stat_mem_pkt_yumi_i,
    output logic                       busy_o,
    output logic                       fill_done_o
);

    localparam int offset_width_lp = $clog2(block_width_p/8);
    localparam int index_width_lp  = $clog2(sets_p);
    localparam int way_width_lp    = $clog2(ways_p);
    localparam int tag_width_lp    = paddr_width_p - index_width_lp - offset_width_lp;

    bp_fill_state_e              state_r, state_n;
    logic [index_width_lp-1:0]   index_r;
    logic [tag_width_lp-1:0]     tag_r;
    logic [way_width_lp-1:0]     way_r;
    logic [block_width_p-1:0]    data_r;
    logic                        done_r;

    // Byte offset within the line plays no part in a whole-line fill.
    logic unused_offset_bits;
    assign unused_offset_bits = ^fill_addr_i[offset_width_lp-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            index_r <= '0;
            tag_r   <= '0;
            way_r   <= '0;
            data_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            done_r  <= stat_mem_pkt_v_o & stat_mem_pkt_yumi_i;
            if (fill_yumi_o) begin
                index_r <= fill_addr_i[offset_width_lp +: index_width_lp];
                tag_r   <= fill_addr_i[paddr_width_p-1 -: tag_width_lp];
                way_r   <= fill_way_i;
                data_r  <= fill_data_i;
            end
        end
    end

    always_comb begin
        state_n          = state_r;
        fill_yumi_o      = 1'b0;
        data_mem_pkt_v_o = 1'b0;
        tag_mem_pkt_v_o  = 1'b0;
        stat_mem_pkt_v_o = 1'b0;
        unique case (state_r)
            e_ready: begin
                fill_yumi_o = fill_v_i;
                if (fill_v_i) state_n = e_data;
            end
            e_data: begin
                data_mem_pkt_v_o = 1'b1;
                if (data_mem_pkt_yumi_i) state_n = e_tag;
            end
            e_tag: begin
                tag_mem_pkt_v_o = 1'b1;
                if (tag_mem_pkt_yumi_i) state_n = e_stat;
            end
            e_stat: begin
                stat_mem_pkt_v_o = 1'b1;
                if (stat_mem_pkt_yumi_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    // Packets are driven to zero whenever their valid is low.
    always_comb begin
        data_mem_pkt_o = '0;
        tag_mem_pkt_o  = '0;
        stat_mem_pkt_o = '0;
        if (data_mem_pkt_v_o) begin
            data_mem_pkt_o.opcode = e_data_mem_write;
            data_mem_pkt_o.index  = index_r;
            data_mem_pkt_o.way    = way_r;
            data_mem_pkt_o.data   = data_r;
        end
        if (tag_mem_pkt_v_o) begin
            tag_mem_pkt_o.opcode = e_tag_mem_set_tag;
            tag_mem_pkt_o.index  = index_r;
            tag_mem_pkt_o.way    = way_r;
            tag_mem_pkt_o.state  = e_coh_exclusive;
            tag_mem_pkt_o.tag    = tag_r;
        end
        if (stat_mem_pkt_v_o) begin
            stat_mem_pkt_o.opcode = e_stat_mem_set_clear;
            stat_mem_pkt_o.index  = index_r;
            stat_mem_pkt_o.way    = way_r;
        end
    end

    assign busy_o      = (state_r != e_ready);
    assign fill_done_o = done_r;

endmodule

// File: tb/tb_bp_l15_fill_engine.sv
// Directed bench for bp_l15_fill_engine with a queue-based scoreboard that
// checks every consumed packet and completion pulse in order.
module tb_bp_l15_fill_engine;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           fill_v_i;
    logic [39:0]    fill_addr_i;
    logic [2:0]     fill_way_i;
    logic [511:0]   fill_data_i;
    logic           fill_yumi_o;
    logic [522:0]   data_mem_pkt_o;
    logic           data_mem_pkt_v_o;
    logic           data_mem_pkt_yumi_i;
    logic [41:0]    tag_mem_pkt_o;
    logic           tag_mem_pkt_v_o;
    logic           tag_mem_pkt_yumi_i;
    logic [10:0]    stat_mem_pkt_o;
    logic           stat_mem_pkt_v_o;
    logic           stat_mem_pkt_yumi_i;
    logic           busy_o;
    logic           fill_done_o;

    bp_l15_fill_engine dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .fill_v_i            (fill_v_i),
        .fill_addr_i         (fill_addr_i),
        .fill_way_i          (fill_way_i),
        .fill_data_i         (fill_data_i),
        .fill_yumi_o         (fill_yumi_o),
        .data_mem_pkt_o      (data_mem_pkt_o),
        .data_mem_pkt_v_o    (data_mem_pkt_v_o),
        .data_mem_pkt_yumi_i (data_mem_pkt_yumi_i),
        .tag_mem_pkt_o       (tag_mem_pkt_o),
        .tag_mem_pkt_v_o     (tag_mem_pkt_v_o),
        .tag_mem_pkt_yumi_i  (tag_mem_pkt_yumi_i),
        .stat_mem_pkt_o      (stat_mem_pkt_o),
        .stat_mem_pkt_v_o    (stat_mem_pkt_v_o),
        .stat_mem_pkt_yumi_i (stat_mem_pkt_yumi_i),
        .busy_o              (busy_o),
        .fill_done_o         (fill_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]   kind;
        logic [522:0] pkt;
    } exp_t;

    localparam logic [1:0] K_DATA = 2'd0, K_TAG = 2'd1, K_STAT = 2'd2, K_DONE = 2'd3;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [522:0] act, input logic [522:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_fill(input logic [5:0] idx, input logic [27:0] tag,
                             input logic [2:0] way, input logic [511:0] data);
        exp_t e;
        e.kind = K_DATA; e.pkt = {2'b01, idx, way, data};
        sb.push_back(e);
        e.kind = K_TAG;  e.pkt = '0; e.pkt[41:0] = {2'b01, idx, way, 3'b010, tag};
        sb.push_back(e);
        e.kind = K_STAT; e.pkt = '0; e.pkt[10:0] = {2'b01, idx, way};
        sb.push_back(e);
        e.kind = K_DONE; e.pkt = '0;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [522:0] act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind %0d pkt %h want nothing", kind, act);
        end else begin
            e = sb.pop_front();
            if (e.kind !== kind || e.pkt !== act) begin
                bad++;
                $display("FAIL sb_order: got kind %0d pkt %h want kind %0d pkt %h",
                         kind, act, e.kind, e.pkt);
            end
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        total++;
        if ($countones({data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o}) > 1) begin
            bad++;
            $display("FAIL one_valid: got %b want at most one set",
                     {data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o});
        end
        if (!data_mem_pkt_v_o) check("data_pkt_idle_zero", data_mem_pkt_o, '0);
        if (!tag_mem_pkt_v_o)  check("tag_pkt_idle_zero", tag_mem_pkt_o, '0);
        if (!stat_mem_pkt_v_o) check("stat_pkt_idle_zero", stat_mem_pkt_o, '0);
        if (data_mem_pkt_v_o && data_mem_pkt_yumi_i) sb_pop(K_DATA, data_mem_pkt_o);
        if (tag_mem_pkt_v_o && tag_mem_pkt_yumi_i)   sb_pop(K_TAG, tag_mem_pkt_o);
        if (stat_mem_pkt_v_o && stat_mem_pkt_yumi_i) sb_pop(K_STAT, stat_mem_pkt_o);
        if (fill_done_o) sb_pop(K_DONE, '0);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [39:0] addr, input logic [2:0] way, input logic [511:0] data);
        fill_v_i    = 1'b1;
        fill_addr_i = addr;
        fill_way_i  = way;
        fill_data_i = data;
    endtask

    initial begin
        reset_n_i           = 1'b0;
        fill_v_i            = 1'b0;
        fill_addr_i         = '0;
        fill_way_i          = '0;
        fill_data_i         = '0;
        data_mem_pkt_yumi_i = 1'b0;
        tag_mem_pkt_yumi_i  = 1'b0;
        stat_mem_pkt_yumi_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_data_v", data_mem_pkt_v_o, 0);
        check("rst_tag_v", tag_mem_pkt_v_o, 0);
        check("rst_stat_v", stat_mem_pkt_v_o, 0);
        check("rst_done", fill_done_o, 0);
        check("rst_fill_yumi", fill_yumi_o, 0);
        reset_n_i           = 1'b1;
        data_mem_pkt_yumi_i = 1'b1;
        tag_mem_pkt_yumi_i  = 1'b1;
        stat_mem_pkt_yumi_i = 1'b1;
        tick();

        // Basic fill, all yumis high
        push_fill(6'h09, 28'hABCDEF1, 3'd5, {16{32'hDEADBEEF}});
        issue(40'hAB_CDEF_1240, 3'd5, {16{32'hDEADBEEF}});
        #1 check("basic_accept", fill_yumi_o, 1);
        tick();
        fill_v_i = 1'b0;
        check("basic_c1_data_v", data_mem_pkt_v_o, 1);
        check("basic_c1_data_pkt", data_mem_pkt_o, {2'b01, 6'h09, 3'd5, {16{32'hDEADBEEF}}});
        check("basic_c1_busy", busy_o, 1);
        tick();
        check("basic_c2_tag_v", tag_mem_pkt_v_o, 1);
        check("basic_c2_tag_pkt", tag_mem_pkt_o, {2'b01, 6'h09, 3'd5, 3'b010, 28'hABCDEF1});
        tick();
        check("basic_c3_stat_v", stat_mem_pkt_v_o, 1);
        check("basic_c3_done_lo", fill_done_o, 0);
        tick();
        check("basic_c4_done", fill_done_o, 1);
        check("basic_c4_busy", busy_o, 0);
        tick();
        check("basic_c5_done_lo", fill_done_o, 0);

        // Back-pressure on the tag packet
        tag_mem_pkt_yumi_i = 1'b0;
        push_fill(6'h22, 28'h1234567, 3'd2, {8{64'h0123_4567_89AB_CDEF}});
        issue(40'h12_3456_7880, 3'd2, {8{64'h0123_4567_89AB_CDEF}});
        tick();
        fill_v_i = 1'b0;
        check("bp_data_v", data_mem_pkt_v_o, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_tag_held_v", tag_mem_pkt_v_o, 1);
            check("bp_tag_held_pkt", tag_mem_pkt_o, {2'b01, 6'h22, 3'd2, 3'b010, 28'h1234567});
            check("bp_stat_blocked", stat_mem_pkt_v_o, 0);
            tick();
        end
        tag_mem_pkt_yumi_i = 1'b1;
        tick();
        check("bp_stat_v", stat_mem_pkt_v_o, 1);
        tick();
        check("bp_done", fill_done_o, 1);
        tick();

        // Fill request held while busy
        push_fill(6'h15, 28'h5555555, 3'd1, {16{32'h1111_2222}});
        push_fill(6'h01, 28'h8000000, 3'd6, {16{32'h3333_4444}});
        issue(40'h55_5555_5555, 3'd1, {16{32'h1111_2222}});
        #1 check("busy_a_accept", fill_yumi_o, 1);
        tick();
        issue(40'h80_0000_0040, 3'd6, {16{32'h3333_4444}});
        for (int i = 1; i < 4; i++) begin
            #1;
            check("busy_b_not_taken", fill_yumi_o, 0);
            check("busy_b_busy", busy_o, 1);
            tick();
        end
        check("busy_a_done", fill_done_o, 1);
        check("busy_b_accept_at_done", fill_yumi_o, 1);
        tick();
        fill_v_i = 1'b0;
        check("busy_b_data_v", data_mem_pkt_v_o, 1);
        repeat (3) tick();
        check("busy_b_done", fill_done_o, 1);
        tick();

        // Spurious yumis while idle
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_busy", busy_o, 0);
            check("idle_done", fill_done_o, 0);
            check("idle_valids", {data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o}, 0);
        end

        // Asynchronous reset during the tag phase
        push_fill(6'h2A, 28'h0000002, 3'd3, {16{32'h0F0F_F0F0}});
        issue(40'h00_0000_2A80, 3'd3, {16{32'h0F0F_F0F0}});
        tick();
        fill_v_i = 1'b0;
        tick();
        check("arst_in_tag", tag_mem_pkt_v_o, 1);
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_tag_v", tag_mem_pkt_v_o, 0);
        check("arst_valids", {data_mem_pkt_v_o, stat_mem_pkt_v_o}, 0);
        check("arst_busy", busy_o, 0);
        check("arst_pending", sb.size(), 3);
        sb.delete();
        @(posedge clk_i);
        #3 reset_n_i = 1'b1;
        tick();

        // Address boundary after reset
        push_fill(6'h3F, 28'hFFFFFFF, 3'd7, {16{32'hA5A5_5A5A}});
        issue(40'hFF_FFFF_FFFF, 3'd7, {16{32'hA5A5_5A5A}});
        tick();
        fill_v_i = 1'b0;
        check("bnd_data_v", data_mem_pkt_v_o, 1);
        check("bnd_index", data_mem_pkt_o[520:515], 6'h3F);
        check("bnd_way", data_mem_pkt_o[514:512], 3'd7);
        tick();
        check("bnd_tag", tag_mem_pkt_o[27:0], 28'hFFFFFFF);
        tick();
        check("bnd_stat_pkt", stat_mem_pkt_o, {2'b01, 6'h3F, 3'd7});
        tick();
        check("bnd_done", fill_done_o, 1);
        tick();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_l15_fill_engine.md
Name: bp_l15_fill_engine

Overview:
- Downstream of the BP↔L1.5 transducer's load path. Consumes one fully assembled 512-bit miss cacheline plus its miss address and victim way.
- Writes the line into the BlackParrot D-cache as three ordered packets: data_mem_pkt, then tag_mem_pkt, then stat_mem_pkt. Each packet uses a valid/yumi handshake.
- Signals completion so the transducer can release its miss entry.

Parameters:
- paddr_width_p, 40, physical address width
- sets_p, 64, cache sets; index width = log2(sets_p) = 6
- ways_p, 8, associativity; way width = log2(ways_p) = 3
- block_width_p, 512, cacheline bits; offset width = log2(block_width_p/8) = 6

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- fill_v_i  in  1  fill request valid
- fill_addr_i  in  40  miss physical address
- fill_way_i  in  3  victim (LRU) way
- fill_data_i  in  512  assembled cacheline
- fill_yumi_o  out  1  fill request consumed this cycle
- data_mem_pkt_o  out  523  {opcode[1:0], index[5:0], way[2:0], data[511:0]}
- data_mem_pkt_v_o  out  1  data packet valid
- data_mem_pkt_yumi_i  in  1  data packet consumed
- tag_mem_pkt_o  out  42  {opcode[1:0], index[5:0], way[2:0], state[2:0], tag[27:0]}
- tag_mem_pkt_v_o  out  1  tag packet valid
- tag_mem_pkt_yumi_i  in  1  tag packet consumed
- stat_mem_pkt_o  out  11  {opcode[1:0], index[5:0], way[2:0]}
- stat_mem_pkt_v_o  out  1  stat packet valid
- stat_mem_pkt_yumi_i  in  1  stat packet consumed
- busy_o  out  1  fill in progress
- fill_done_o  out  1  one-cycle pulse after stat packet consumed

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values: state = e_ready. All *_v_o, fill_yumi_o, busy_o and fill_done_o are 0. Captured registers are cleared to 0.
- Reset mid-operation: the in-flight fill is dropped and no further packets are issued. The upstream must reissue it.
- FSM states: e_ready, e_data, e_tag, e_stat.
- e_ready:
  - fill_yumi_o = fill_v_i (combinational).
  - On fill_v_i: capture index = fill_addr_i[11:6], tag = fill_addr_i[39:12], way, and data; go to e_data.
  - fill_addr_i[5:0] is ignored.
- e_data:
  - data_mem_pkt_v_o = 1, opcode = e_data_mem_write.
  - On data_mem_pkt_yumi_i, go to e_tag.
- e_tag:
  - tag_mem_pkt_v_o = 1, opcode = e_tag_mem_set_tag, state = e_coh_exclusive.
  - On tag_mem_pkt_yumi_i, go to e_stat.
- e_stat:
  - stat_mem_pkt_v_o = 1, opcode = e_stat_mem_set_clear.
  - On stat_mem_pkt_yumi_i, go to e_ready and assert fill_done_o (registered) in the following cycle.
- Valid/yumi rules:
  - At most one *_v_o is high in any cycle.
  - The tag write always follows data, so the line never becomes valid over stale data.
  - Packet contents come from registers and are stable while v_o is high.
  - Each pkt_o is all-zero when its v_o is low.
  - A yumi asserted while its v_o is low is ignored.
- busy_o = (state != e_ready).
- Latency and throughput:
  - Fill accepted in cycle N gives data_mem_pkt_v_o in cycle N+1.
  - With yumi tied high, cycle-by-cycle: data N+1, tag N+2, stat N+3, fill_done_o N+4.
  - The next accept is possible at N+4 (same cycle as fill_done_o).
  - fill_v_i arriving while busy is not consumed.
- Back-pressure: any yumi held low stalls the FSM indefinitely in its state with v_o held high.

Decomposition:
- A shared package bp_l15_pkg holds:
  - opcode enums: e_data_mem_write = 2'b01, e_tag_mem_set_tag = 2'b01, e_stat_mem_set_clear = 2'b01;
  - coherence state e_coh_exclusive = 3'b010;
  - packed struct typedefs for the three packets;
  - FSM state enum.
- No sub-module is needed; this is a single FSM plus a capture register.

Test Plan:
- Reset then basic fill, all yumis tied high:
  - Stimulus: fill_addr = 40'hAB_CDEF_1240, way 5, data = {16{32'hDEADBEEF}}.
  - Required: data pkt index 6'h09, way 5, data exact at cycle 1; tag pkt tag 28'hABCDEF1, state 3'b010 at cycle 2; stat pkt at cycle 3; fill_done_o at cycle 4.
- Back-pressure:
  - Stimulus: hold tag_mem_pkt_yumi_i low for 10 cycles.
  - Required: tag_mem_pkt_v_o stays high with a constant packet; stat is not issued until yumi arrives.
- Fill while busy:
  - Stimulus: fill_v_i high continuously with two distinct requests.
  - Required: the second is yumi'd only at the fill_done_o cycle; packet order is data/tag/stat for A, then for B.
- Spurious yumi:
  - Stimulus: assert all three yumis while idle.
  - Required: no state change and no fill_done_o.
- Asynchronous reset mid-fill:
  - Stimulus: drop reset_n_i during e_tag, between clock edges.
  - Required: all v_o and busy_o go to 0 immediately; after release, a new fill completes normally.
- Address boundary:
  - Stimulus: fill_addr = 40'hFF_FFFF_FFFF, way 7.
  - Required: index 6'h3F, tag 28'hFFFFFFF, way 7.
